// File: rtl/core8_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NUM_REQ Avalon-MM masters.
// Optional bus locking is compiled in when MEM_ARB_LOCK_EN is defined.
module core8_mem_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_byteenable,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic                          hold,
    output logic [NUM_REQ-1:0]            req_waitrequest,
    output logic [DATA_W-1:0]             req_readdata,
    output logic [NUM_REQ-1:0]            req_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W/8-1:0]           mem_byteenable,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic                          mem_clken,
    input  logic [DATA_W-1:0]             mem_readdata
);
    localparam int BE_W = DATA_W / 8;
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Core index base+offset, wrapped modulo NUM_REQ (offset < NUM_REQ).
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return ID_W'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    logic [NUM_REQ-1:0] requesting_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_id_s;
    logic               gnt_any_s;
    logic [ID_W-1:0]    ptr_r;
    logic               rd_v1_r;
    logic [ID_W-1:0]    rd_id1_r;
    logic [NUM_REQ-1:0] rdv_r;
    logic [ADDR_W-1:0]  mem_address_r;
    logic [BE_W-1:0]    mem_byteenable_r;
    logic               mem_chipselect_r;
    logic               mem_write_r;
    logic [DATA_W-1:0]  mem_writedata_r;

    assign requesting_s = req_read | req_write;

`ifdef MEM_ARB_LOCK_EN
    logic            lock_valid_r;
    logic [ID_W-1:0] lock_owner_r;

    // While locked, only the lock owner may compete for the memory.
    always_comb begin
        eligible_s = requesting_s;
        if (lock_valid_r) begin
            eligible_s = requesting_s & onehot(lock_owner_r);
        end else begin
            eligible_s = requesting_s;
        end
    end

    // Lock ownership: set by a locked accept, released by the owner's next unlocked accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_r <= 1'b0;
            lock_owner_r <= '0;
        end else if (gnt_any_s) begin
            lock_valid_r <= req_lock[gnt_id_s];
            lock_owner_r <= gnt_id_s;
        end else begin
            lock_valid_r <= lock_valid_r;
            lock_owner_r <= lock_owner_r;
        end
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = ^req_lock;
    assign eligible_s    = requesting_s;
`endif

    // Round-robin search from ptr; scanning downward lets the nearest requester win.
    always_comb begin
        gnt_s     = '0;
        gnt_id_s  = '0;
        gnt_any_s = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible_s[rr_index(ptr_r, k)] && !hold) begin
                gnt_id_s  = rr_index(ptr_r, k);
                gnt_any_s = 1'b1;
            end else begin
                gnt_id_s  = gnt_id_s;
                gnt_any_s = gnt_any_s;
            end
        end
        if (gnt_any_s) begin
            gnt_s = onehot(gnt_id_s);
        end else begin
            gnt_s = '0;
        end
    end

    assign req_waitrequest = requesting_s & ~gnt_s;

    // Command register, round-robin pointer and read-response tag pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r            <= '0;
            mem_address_r    <= '0;
            mem_byteenable_r <= '0;
            mem_writedata_r  <= '0;
            mem_chipselect_r <= 1'b0;
            mem_write_r      <= 1'b0;
            rd_v1_r          <= 1'b0;
            rd_id1_r         <= '0;
            rdv_r            <= '0;
        end else begin
            if (gnt_any_s) begin
                ptr_r            <= rr_index(gnt_id_s, 1);
                mem_address_r    <= req_address[int'(gnt_id_s)*ADDR_W +: ADDR_W];
                mem_byteenable_r <= req_byteenable[int'(gnt_id_s)*BE_W +: BE_W];
                mem_writedata_r  <= req_writedata[int'(gnt_id_s)*DATA_W +: DATA_W];
                mem_write_r      <= req_write[gnt_id_s];
            end else begin
                ptr_r            <= ptr_r;
                mem_address_r    <= mem_address_r;
                mem_byteenable_r <= mem_byteenable_r;
                mem_writedata_r  <= mem_writedata_r;
                mem_write_r      <= 1'b0;
            end
            mem_chipselect_r <= gnt_any_s;
            rd_v1_r          <= gnt_any_s & ~req_write[gnt_id_s];
            rd_id1_r         <= gnt_id_s;
            rdv_r            <= rd_v1_r ? onehot(rd_id1_r) : {NUM_REQ{1'b0}};
        end
    end

    assign mem_address       = mem_address_r;
    assign mem_byteenable    = mem_byteenable_r;
    assign mem_chipselect    = mem_chipselect_r;
    assign mem_write         = mem_write_r;
    assign mem_writedata     = mem_writedata_r;
    assign mem_clken         = 1'b1;
    assign req_readdatavalid = rdv_r;
    assign req_readdata      = mem_readdata;

endmodule

// File: tb/tb_core8_mem_arbiter.sv
// Self-checking bench for core8_mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of arbitration and memory contents.
module tb_core8_mem_arbiter;
    localparam int N  = 8;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*AW-1:0] req_address;
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_writedata;
    logic [N*BW-1:0] req_byteenable;
    logic [N-1:0]    req_lock;
    logic            hold;
    logic [N-1:0]    req_waitrequest;
    logic [DW-1:0]   req_readdata;
    logic [N-1:0]    req_readdatavalid;
    logic [AW-1:0]   mem_address;
    logic [BW-1:0]   mem_byteenable;
    logic            mem_chipselect;
    logic            mem_write;
    logic [DW-1:0]   mem_writedata;
    logic            mem_clken;
    logic [DW-1:0]   mem_readdata;

    core8_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_address(req_address), .req_read(req_read), .req_write(req_write),
        .req_writedata(req_writedata), .req_byteenable(req_byteenable), .req_lock(req_lock),
        .hold(hold), .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    // Environment: the single-port memory behind the arbiter, one-cycle read latency.
    logic [31:0] mem_array [0:8191];
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            for (int b = 0; b < BW; b++) begin
                if (mem_byteenable[b]) mem_array[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
        end
        mem_readdata <= mem_array[mem_address];
    end

    // Reference model state
    typedef struct { int due; int owner; logic [31:0] data; } rsp_t;
    rsp_t        rsp_q[$];
    logic [31:0] model_mem [0:8191];
    int          m_ptr = 0;
    bit          m_lv = 1'b0;
    int          m_lo = 0;
    bit          m_started = 1'b0;
    int          cyc = 0;
    logic        exp_cs = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_addr = 32'd0, exp_be = 32'd0, exp_wd = 32'd0;

    int n_pass = 0;
    int n_total = 0;

    // Observation helpers for directed scenarios
    logic [N-1:0] acc_mask = '0;
    bit           log_en = 1'b0;
    int           acc_log[$];
    int           rdv_seen = 0;
    logic [31:0]  cap_data [0:N-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    function automatic int model_grant(input logic [N-1:0] rq, input logic h, input int p,
                                       input bit lv, input int lo);
        if (h) return -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (rq[c] && (!lv || c == lo)) return c;
        end
        return -1;
    endfunction

    function automatic int first_set(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int log_at(input int k);
        return (acc_log.size() > k) ? acc_log[k] : -2;
    endfunction

    initial begin
        for (int a = 0; a < 8192; a++) begin
            mem_array[a] = init_word(a);
            model_mem[a] = init_word(a);
        end
    end

    // Model: one arbitration decision per edge, memory contents tracked at accept time.
    initial begin : model_proc
        int g;
        int a;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_ptr = 0; m_lv = 1'b0; m_lo = 0; m_started = 1'b1;
                exp_cs = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_be = 32'd0; exp_wd = 32'd0;
                rsp_q.delete();
            end else if (m_started) begin
                g = model_grant(req_read | req_write, hold, m_ptr, m_lv, m_lo);
                if (g >= 0) begin
                    a        = int'(req_address[g*AW +: AW]);
                    m_ptr    = (g + 1) % N;
                    exp_cs   = 1'b1;
                    exp_we   = req_write[g];
                    exp_addr = 32'(a);
                    exp_be   = 32'(req_byteenable[g*BW +: BW]);
                    exp_wd   = req_writedata[g*DW +: DW];
                    if (req_write[g]) begin
                        for (int b = 0; b < BW; b++)
                            if (req_byteenable[g*BW + b]) model_mem[a][b*8 +: 8] = req_writedata[g*DW + b*8 +: 8];
                    end else begin
                        rsp_q.push_back('{cyc + 2, g, model_mem[a]});
                    end
`ifdef MEM_ARB_LOCK_EN
                    m_lv = req_lock[g];
                    m_lo = g;
`endif
                end else begin
                    exp_cs = 1'b0;
                    exp_we = 1'b0;
                end
            end
            cyc++;
        end
    end

    // Compare: every falling edge once the first reset has been seen.
    initial begin : cmp_proc
        int g;
        logic [N-1:0] rq, exp_wait, exp_rdv;
        logic [31:0]  exp_rd;
        forever begin
            @(negedge clk);
            rq = req_read | req_write;
            acc_mask = rq & ~req_waitrequest;
            if (log_en) acc_log.push_back(first_set(acc_mask));
            if (req_readdatavalid != '0) begin
                rdv_seen++;
                for (int i = 0; i < N; i++) if (req_readdatavalid[i]) cap_data[i] = req_readdata;
            end
            if (m_started) begin
                g = model_grant(rq, hold, m_ptr, m_lv, m_lo);
                exp_wait = rq;
                if (g >= 0) exp_wait[g] = 1'b0;
                check("waitrequest", 32'(req_waitrequest), 32'(exp_wait));
                check("mem_chipselect", 32'(mem_chipselect), 32'(exp_cs));
                check("mem_write", 32'(mem_write), 32'(exp_we));
                check("mem_address", 32'(mem_address), exp_addr);
                check("mem_byteenable", 32'(mem_byteenable), exp_be);
                check("mem_writedata", mem_writedata, exp_wd);
                check("mem_clken", 32'(mem_clken), 32'd1);
                exp_rdv = '0;
                exp_rd  = 32'd0;
                if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                    exp_rdv[rsp_q[0].owner] = 1'b1;
                    exp_rd = rsp_q[0].data;
                    void'(rsp_q.pop_front());
                end
                check("readdatavalid", 32'(req_readdatavalid), 32'(exp_rdv));
                if (exp_rdv != '0) check("readdata", req_readdata, exp_rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req_address = '0; req_read = '0; req_write = '0;
        req_writedata = '0; req_byteenable = '0; req_lock = '0;
    endtask

    task automatic set_cmd(input int i, input bit rd, input bit wr, input int addr,
                           input logic [31:0] wd, input logic [3:0] be, input bit lk);
        req_read[i] = rd;
        req_write[i] = wr;
        req_address[i*AW +: AW] = AW'(addr);
        req_writedata[i*DW +: DW] = wd;
        req_byteenable[i*BW +: BW] = be;
        req_lock[i] = lk;
    endtask

    // Masters hold their command until accepted; bounded by a cycle budget.
    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((req_read | req_write) != '0 && k < budget) begin
            step();
            req_read  = req_read & ~acc_mask;
            req_write = req_write & ~acc_mask;
            req_lock  = req_lock & ~acc_mask;
            k++;
        end
        check("drain_done", 32'((req_read | req_write) == '0), 32'd1);
    endtask

    initial begin
        int kind;
        reset = 1'b1; hold = 1'b0; clear_all();
        repeat (3) step();
        reset = 1'b0;
        check("rst_chipselect", 32'(mem_chipselect), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_address", 32'(mem_address), 32'd0);
        check("rst_byteenable", 32'(mem_byteenable), 32'd0);
        check("rst_writedata", mem_writedata, 32'd0);
        check("rst_rdv", 32'(req_readdatavalid), 32'd0);

        // All cores read i*16 together: accepts 0..7 in order.
        for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 1'b0, i * 16, 32'd0, 4'hF, 1'b0);
        acc_log.delete(); log_en = 1'b1;
        drain(20);
        log_en = 1'b0;
        for (int k = 0; k < N; k++) check("rr_order", 32'(log_at(k)), 32'(k));
        repeat (3) step();
        check("rd_core0", cap_data[0], 32'hC0DE0000);
        check("rd_core3", cap_data[3], 32'hC0DE0030);
        check("rd_core7", cap_data[7], 32'hC0DE0070);

        // Byte-enable merge followed by a read from another core.
        set_cmd(3, 1'b0, 1'b1, 16, 32'hDEADBEEF, 4'hF, 1'b0); drain(5);
        set_cmd(3, 1'b0, 1'b1, 16, 32'h00001234, 4'h3, 1'b0); drain(5);
        set_cmd(5, 1'b1, 1'b0, 16, 32'd0, 4'hF, 1'b0); drain(5);
        repeat (3) step();
        check("be_merge", cap_data[5], 32'hDEAD1234);

        // Cores 0 and 1 continuously requesting alternate (ptr is 6 here).
        set_cmd(0, 1'b1, 1'b0, 1, 32'd0, 4'hF, 1'b0);
        set_cmd(1, 1'b1, 1'b0, 2, 32'd0, 4'hF, 1'b0);
        acc_log.delete(); log_en = 1'b1;
        repeat (10) step();
        log_en = 1'b0; clear_all();
        for (int k = 0; k < 10; k++) check("alternate", 32'(log_at(k)), 32'(k % 2));
        repeat (3) step();

        // Move ptr to 5, hold with cores 2 and 6 waiting, then release.
        set_cmd(4, 1'b1, 1'b0, 3, 32'd0, 4'hF, 1'b0); drain(5);
        hold = 1'b1;
        set_cmd(2, 1'b1, 1'b0, 4, 32'd0, 4'hF, 1'b0);
        set_cmd(6, 1'b1, 1'b0, 5, 32'd0, 4'hF, 1'b0);
        repeat (4) begin
            step();
            check("hold_cs", 32'(mem_chipselect), 32'd0);
            check("hold_wait", 32'(req_waitrequest), 32'h44);
        end
        hold = 1'b0;
        acc_log.delete(); log_en = 1'b1;
        drain(6);
        log_en = 1'b0;
        check("hold_rel0", 32'(log_at(0)), 32'd6);
        check("hold_rel1", 32'(log_at(1)), 32'd2);
        repeat (3) step();

        // Lock scenario: ptr set to 2 first.
        set_cmd(1, 1'b1, 1'b0, 6, 32'd0, 4'hF, 1'b0); drain(5);
        acc_log.delete(); log_en = 1'b1;
        clear_all(); set_cmd(2, 1'b1, 1'b0, 5, 32'd0, 4'hF, 1'b1); set_cmd(4, 1'b1, 1'b0, 6, 32'd0, 4'hF, 1'b0); step();
        clear_all(); set_cmd(4, 1'b1, 1'b0, 6, 32'd0, 4'hF, 1'b0); step();
        step();
        clear_all(); set_cmd(2, 1'b0, 1'b1, 7, 32'h12345678, 4'hF, 1'b0); set_cmd(4, 1'b1, 1'b0, 6, 32'd0, 4'hF, 1'b0); step();
        clear_all(); set_cmd(4, 1'b1, 1'b0, 6, 32'd0, 4'hF, 1'b0); step();
        log_en = 1'b0; clear_all();
`ifdef MEM_ARB_LOCK_EN
        check("lock_c0", 32'(log_at(0)), 32'd2);
        check("lock_c1", 32'(log_at(1)), 32'hFFFFFFFF);
        check("lock_c2", 32'(log_at(2)), 32'hFFFFFFFF);
        check("lock_c3", 32'(log_at(3)), 32'd2);
        check("lock_c4", 32'(log_at(4)), 32'd4);
`else
        check("nolock_c0", 32'(log_at(0)), 32'd2);
        check("nolock_c1", 32'(log_at(1)), 32'd4);
        check("nolock_c2", 32'(log_at(2)), 32'd4);
        check("nolock_c3", 32'(log_at(3)), 32'd2);
        check("nolock_c4", 32'(log_at(4)), 32'd4);
`endif
        repeat (3) step();

        // Reset right after a read accept drops its response.
        set_cmd(1, 1'b1, 1'b0, 48, 32'd0, 4'hF, 1'b0);
        step();
        clear_all(); reset = 1'b1; rdv_seen = 0;
        step();
        reset = 1'b0;
        check("rst_mid_cs", 32'(mem_chipselect), 32'd0);
        step(); step();
        check("rst_mid_rdv", 32'(rdv_seen), 32'd0);

        // Randomized traffic with occasional hold, lock and reset.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                kind = int'($urandom_range(0, 5));
                set_cmd(i, (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                        int'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 7) == 0));
            end
            hold  = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        clear_all(); hold = 1'b0; reset = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/core8_mem_arbiter.md
# core8_mem_arbiter

Round-robin arbiter that shares one single-port 8192 x 32 on-chip memory between the eight Nios cores of the 8-core platform. Each core sees an Avalon-MM-style slave port with waitrequest and readdatavalid. The arbiter registers one granted command per cycle onto the memory's address, byteenable, chipselect, write and writedata pins, and routes the memory's one-cycle-latency read data back to the owning core. It sits between the per-core data masters and the memory instance's s1 port.

## Interface
- NUM_REQ, 8, number of requesting cores (2..16)
- ADDR_W, 13, word address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- req_address  in  NUM_REQ*ADDR_W  per-core word address, core i at [i*ADDR_W +: ADDR_W]
- req_read  in  NUM_REQ  per-core read request
- req_write  in  NUM_REQ  per-core write request
- req_writedata  in  NUM_REQ*DATA_W  per-core write data
- req_byteenable  in  NUM_REQ*DATA_W/8  per-core byte enables
- req_lock  in  NUM_REQ  per-core lock request (used only with MEM_ARB_LOCK_EN)
- hold  in  1  blocks new grants; in-flight reads still complete
- req_waitrequest  out  NUM_REQ  command not accepted this cycle
- req_readdata  out  DATA_W  read data, shared by all cores
- req_readdatavalid  out  NUM_REQ  one-hot; qualifies req_readdata for core i
- mem_address  out  ADDR_W  registered memory address
- mem_byteenable  out  DATA_W/8  registered byte enables
- mem_chipselect  out  1  registered; high for any issued command
- mem_write  out  1  registered write strobe
- mem_writedata  out  DATA_W  registered write data
- mem_clken  out  1  tied high
- mem_readdata  in  DATA_W  memory output; valid the cycle after the address is presented

## Operation
- Core i is requesting when req_read[i] | req_write[i]. If both are high, the command is a write and the read is ignored.
- Grant is combinational from the current requests and a registered pointer `ptr`. Search runs ptr, ptr+1, … modulo NUM_REQ; the first requester wins. gnt is one-hot or zero.
- req_waitrequest[i] = requesting[i] & ~gnt[i]. Non-requesting cores see waitrequest low.
- When hold=1, gnt is 0 and every requesting core sees waitrequest high.
- On accept (gnt[i]=1):
  - ptr ← (i+1) mod NUM_REQ.
  - mem_* registers load core i's command. mem_chipselect=1; mem_write = write.
- No accept: mem_chipselect=0 and mem_write=0. Address, data and byteenable hold their previous values.
- Read tracking: a 2-stage shift register of {valid, owner id} tags each accepted read. Stage 2 drives req_readdatavalid[owner]. Writes produce no response.
- req_readdata = mem_readdata, passed through combinationally.
- Throughput: one command per cycle sustained. Reads and writes may interleave back-to-back.
- Read-after-write to the same address in consecutive accepts returns the new data, because the memory writes on the edge before the read address is sampled.

## Timing
- Accept at cycle N (waitrequest low).
- mem_* is valid during N+1; the memory samples it at the end of N+1.
- mem_readdata is valid in N+2. req_readdatavalid[owner] is high for exactly cycle N+2. Read latency is 2.
- On reset, the following take effect at the next edge:
  - ptr=0.
  - mem_chipselect=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0.
  - Tracking pipe cleared; req_readdatavalid=0.
  - Lock owner cleared.
- Reset mid-read drops any pending readdatavalid. Waitrequest is combinational, so a core requesting during reset can be granted, but that command is discarded.
- Pointer wrap: a grant to NUM_REQ-1 sets ptr=0.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - An accepted command with req_lock[i]=1 sets lock_valid=1 and lock_owner=i.
  - While locked, only lock_owner is eligible; all other cores see waitrequest high.
  - The lock clears on lock_owner's next accepted command with req_lock=0. That command itself is still executed.
  - hold does not clear the lock.
- MEM_ARB_LOCK_EN undefined: req_lock is ignored and there is no lock state. Arbitration is pure round-robin.

## Test plan
- Reset, then all 8 cores read addresses i*16 in the same cycle → accepts in order 0..7 on 8 consecutive cycles; readdatavalid[i] asserts 2 cycles after each core's accept, carrying mem[i*16].
- Core 3 writes 0x0010 = 0xDEADBEEF with be=0xF, then core 3 writes 0x1234 with be=0x3 → core 5 reading 0x0010 gets 0xDEAD1234.
- Cores 0 and 1 both request continuously for 10 cycles → grants alternate 0,1,0,1…; neither waits more than 1 cycle.
- hold=1 for 4 cycles with cores 2 and 6 requesting → no mem_chipselect, waitrequest high for both. With ptr=5, releasing hold grants 6 then 2.
- MEM_ARB_LOCK_EN: core 2 reads with lock=1 while core 4 requests → core 4 waits until core 2 writes with lock=0, then is granted next cycle. Without the macro, grants interleave 2,4.
- Core 1 read accepted at N, reset asserted in N+1 → no readdatavalid at N+2; mem_chipselect=0 after reset.
